// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : systolic_seq_ctrl
// Brief   : 4x4 matmul pass sequencer; clear/feed/settle/capture, then drains
//           the output memory through a skid FIFO onto a ready/valid stream.
// Revision: 1.0
// ============================================================================
module systolic_seq_ctrl #(
    parameter int N             = 4,
    parameter int DATA_W        = 33,
    parameter int ADDR_W        = 4,
    parameter int FEED_CYCLES   = 7,
    parameter int SETTLE_CYCLES = 4,
    parameter int SKID_DEPTH    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pe_clr,
    output logic              pe_en,
    output logic              feed_valid,
    output logic [2:0]        feed_step,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLEAR   = 3'd1;
    localparam logic [2:0] c_FEED    = 3'd2;
    localparam logic [2:0] c_SETTLE  = 3'd3;
    localparam logic [2:0] c_CAPTURE = 3'd4;
    localparam logic [2:0] c_DRAIN   = 3'd5;
    localparam logic [2:0] c_DONE    = 3'd6;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(N * N - 1);

    logic [2:0]        r_state;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_issue_done;
    logic              r_inflight;
    logic              r_inflight_last;

    logic [DATA_W-1:0] r_fifo_data [SKID_DEPTH];
    logic              r_fifo_last [SKID_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_head_last;
    logic [OCC_W-1:0]  w_occ;

    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_pop       = (r_count != '0) && out_ready;
    assign w_push      = r_inflight;
    assign w_head_last = r_fifo_last[r_rd_ptr];

    // Occupancy once this cycle's pop and returning read settle; one slot is
    // kept for the read issued now, so issuing stops with two words pending.
    assign w_occ   = OCC_W'(r_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
    assign w_issue = (r_state == c_DRAIN) && !r_issue_done &&
                     (w_occ < OCC_W'(SKID_DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt <= '0;
                    if (start) r_state <= c_CLEAR;
                end
                c_CLEAR: begin
                    r_cnt   <= '0;
                    r_state <= c_FEED;
                end
                c_FEED: begin
                    if (r_cnt == 3'(FEED_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= c_SETTLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_SETTLE: begin
                    if (r_cnt == 3'(SETTLE_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= c_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                c_CAPTURE: r_state <= c_DRAIN;
                c_DRAIN: begin
                    if (w_pop && w_head_last) r_state <= c_DONE;
                end
                c_DONE:  r_state <= c_IDLE;
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr          <= '0;
            r_issue_done    <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_addr == c_LAST_ADDR);
            if (r_state == c_DONE) begin
                r_addr       <= '0;
                r_issue_done <= 1'b0;
            end else if (w_issue) begin
                if (r_addr == c_LAST_ADDR) r_issue_done <= 1'b1;
                else                       r_addr       <= r_addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= mem_read_data;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= f_next(r_wr_ptr);
            end
            if (w_pop) r_rd_ptr <= f_next(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign busy          = (r_state != c_IDLE) && (r_state != c_DONE);
    assign done          = (r_state == c_DONE);
    assign pe_clr        = (r_state == c_CLEAR);
    assign pe_en         = (r_state == c_FEED) || (r_state == c_SETTLE);
    assign feed_valid    = (r_state == c_FEED);
    assign feed_step     = (r_state == c_FEED) ? r_cnt : 3'd0;
    assign mem_w_en      = (r_state == c_CAPTURE);
    assign mem_read_addr = r_addr;
    assign out_valid     = (r_count != '0);
    assign out_data      = out_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign out_last      = out_valid && w_head_last;

endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_systolic_seq_ctrl
// Brief   : Directed self-checking bench for systolic_seq_ctrl.
// Revision: 1.0
// ============================================================================
module tb_systolic_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        out_ready = 1'b0;
    logic        busy, done, pe_clr, pe_en, feed_valid, mem_w_en;
    logic        out_valid, out_last;
    logic [2:0]  feed_step;
    logic [3:0]  mem_read_addr;
    logic [32:0] mem_read_data;
    logic [32:0] out_data;
    logic [32:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;

    systolic_seq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pe_clr        (pe_clr),
        .pe_en         (pe_en),
        .feed_valid    (feed_valid),
        .feed_step     (feed_step),
        .mem_w_en      (mem_w_en),
        .mem_read_addr (mem_read_addr),
        .mem_read_data (mem_read_data),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    // Registered-read output memory
    always @(posedge clk) mem_read_data <= mem[mem_read_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ctl();
        return {busy, done, pe_clr, pe_en, feed_valid, mem_w_en, out_valid, out_last};
    endfunction

    function automatic logic [63:0] all_outs();
        return {ctl(), feed_step, mem_read_addr, out_data};
    endfunction

    // Cycle-exact pass with out_ready=1; inject pulses start during FEED and DRAIN
    task automatic timed_pass(input bit inject);
        logic [7:0] e;
        start     = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            start = inject && (k == 5 || k == 20);
            e = {k <= 31, k == 32, k == 1, k >= 2 && k <= 12, k >= 2 && k <= 8,
                 k == 13, k >= 16 && k <= 31, k == 31};
            chk($sformatf("ctl_k%0d", k), ctl(), e);
            chk($sformatf("fstep_k%0d", k), feed_step, (k >= 2 && k <= 8) ? k - 2 : 0);
            chk($sformatf("data_k%0d", k), out_data, (k >= 16 && k <= 31) ? 100 + k - 16 : 0);
        end
        start = 1'b0;
    endtask

    // mode 0: ready=1, mode 1: ready toggles 1,0,..., mode 2: ready=0 for 20 cycles at DRAIN entry
    task automatic stream_pass(input int mode);
        int  idx = 0;
        bit  seen_done = 0;
        start = 1'b1;
        for (int k = 1; k <= 150 && !seen_done; k++) begin
            step();
            start = 1'b0;
            case (mode)
                1:       out_ready = (k % 2 == 1);
                2:       out_ready = !(k >= 14 && k <= 33);
                default: out_ready = 1'b1;
            endcase
            if (mode == 2 && (k == 20 || k == 33))
                chk($sformatf("stall_addr_k%0d", k), mem_read_addr, 2);
            if (out_valid) begin
                chk($sformatf("m%0d_word%0d", mode, idx), out_data, 100 + idx);
                chk($sformatf("m%0d_last%0d", mode, idx), out_last, idx == 15);
                if (out_ready) begin
                    if (mode == 2) chk($sformatf("rate_word%0d", idx), k, 34 + idx);
                    idx++;
                end
            end else begin
                chk($sformatf("m%0d_last_novalid_k%0d", mode, k), out_last, 0);
            end
            if (done) seen_done = 1;
        end
        chk($sformatf("m%0d_count", mode), idx, 16);
        chk($sformatf("m%0d_done_seen", mode), seen_done, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 33'(i + 100);

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #2 chk("reset_outs", all_outs(), 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("idle_busy%0d", i), busy, 0);
        end

        timed_pass(1'b0);
        step();
        timed_pass(1'b1);
        step();
        step();
        stream_pass(1);
        step();
        stream_pass(2);
        step();

        // Reset mid-cycle right after the 7th handshake
        begin
            int hs = 0;
            start     = 1'b1;
            out_ready = 1'b1;
            for (int k = 1; k <= 60 && hs < 7; k++) begin
                step();
                start = 1'b0;
                if (out_valid && out_ready) hs++;
            end
            chk("hs_before_reset", hs, 7);
            step();
            chk("pre_reset_busy", busy, 1);
            #3 rst = 1'b1;
            #1 chk("midcycle_reset_outs", all_outs(), 0);
            step();
            step();
            rst = 1'b0;
            step();
            chk("post_reset_busy", busy, 0);
            stream_pass(0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
